// File: rtl/gate_check_pkg.sv
// Shared definitions for the gate response checkers.
//   state_t       : checker FSM states
//   FUNC_*        : golden-function selector codes
//   golden()      : width-generic reference function (OR / AND / XOR reduction)
package gate_check_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_CHECK,
    ST_DONE
  } state_t;

  localparam int FUNC_OR  = 0;
  localparam int FUNC_AND = 1;
  localparam int FUNC_XOR = 2;

  // Width of the settle counter; holds SETTLE-1 for SETTLE up to 15.
  localparam int SETTLE_W = 4;

  // Reduce the low n bits of vec with the selected function.
  // Unknown codes fall back to OR so the checker stays usable.
  function automatic logic golden(input int func, input int n, input logic [31:0] vec);
    logic acc_or;
    logic acc_and;
    logic acc_xor;
    acc_or  = 1'b0;
    acc_and = 1'b1;
    acc_xor = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (i < n) begin
        acc_or  = acc_or  | vec[i];
        acc_and = acc_and & vec[i];
        acc_xor = acc_xor ^ vec[i];
      end
    end
    case (func)
      FUNC_AND: return acc_and;
      FUNC_XOR: return acc_xor;
      default:  return acc_or;
    endcase
  endfunction

endpackage

// File: rtl/gate_ref_model.sv
// Combinational golden model of a small reduction gate.
//   vec      : input vector applied to the gate
//   expected : response the gate should give for vec
module gate_ref_model
  import gate_check_pkg::*;
#(
  parameter int N_IN = 3,
  parameter int FUNC = FUNC_OR
) (
  input  logic [N_IN-1:0] vec,
  output logic            expected
);

  always_comb begin
    expected = golden(FUNC, N_IN, 32'(vec));
  end

endmodule

// File: rtl/gate_response_checker.sv
// Sweeps every input vector into an external gate, waits SETTLE cycles per
// vector, samples the response once and compares it with a golden function.
//   clk, rst_n        : clock and synchronous active-low reset
//   start             : one-cycle request to begin a sweep (ignored while busy)
//   dut_in / dut_q    : vector driven to the gate / its response
//   busy, done, pass  : sweep status; pass is valid while done=1
//   err_count         : number of mismatching vectors in the last sweep
//   first_fail_vec    : first mismatching vector, valid when first_fail_valid=1
module gate_response_checker
  import gate_check_pkg::*;
#(
  parameter int N_IN   = 3,
  parameter int SETTLE = 2,
  parameter int FUNC   = FUNC_OR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] dut_in,
  input  logic            dut_q,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_fail_vec,
  output logic            first_fail_valid
);

  localparam logic [N_IN-1:0]     VEC_LAST    = '1;
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE - 1);

  state_t                state;
  logic [N_IN-1:0]       vec;
  logic [SETTLE_W-1:0]   settle_cnt;
  logic                  expected;
  logic                  accept;

  gate_ref_model #(
    .N_IN (N_IN),
    .FUNC (FUNC)
  ) u_ref (
    .vec      (vec),
    .expected (expected)
  );

  // vec is a flop that is 0 in IDLE and holds the last vector in DONE,
  // so driving it straight out keeps dut_in registered.
  assign dut_in = vec;

  // The first DONE cycle still shows busy=1 (done rises one edge later),
  // so a start there is treated as "while busy" and dropped.
  assign accept = start && ((state == ST_IDLE) || ((state == ST_DONE) && done));

  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    if (!rst_n) begin
      state            <= ST_IDLE;
      vec              <= '0;
      settle_cnt       <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
    end else if (accept) begin
      state            <= ST_WAIT;
      vec              <= '0;
      settle_cnt       <= '0;
      busy             <= 1'b1;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: ;
        ST_WAIT: begin
          settle_cnt <= settle_cnt + SETTLE_W'(1);
          if (settle_cnt == SETTLE_LAST) state <= ST_CHECK;
        end
        ST_CHECK: begin
          // dut_q is only looked at here, after the vector has settled.
          if (dut_q != expected) begin
            err_count <= err_count + (N_IN + 1)'(1);
            if (!first_fail_valid) begin
              first_fail_vec   <= vec;
              first_fail_valid <= 1'b1;
            end
          end
          if (vec == VEC_LAST) begin
            state <= ST_DONE;
          end else begin
            vec        <= vec + N_IN'(1);
            settle_cnt <= '0;
            state      <= ST_WAIT;
          end
        end
        ST_DONE: begin
          busy <= 1'b0;
          done <= 1'b1;
          pass <= (err_count == '0);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_response_checker.sv
// Self-checking bench for gate_response_checker: an OR-golden checker driven by
// a configurable bench gate, plus an AND-golden checker driven by a correct OR
// gate. Expected sweep results are pushed to a scoreboard on each start and
// popped when done rises.
module tb_gate_response_checker;
  import gate_check_pkg::*;

  localparam int N_IN      = 3;
  localparam int SETTLE    = 2;
  localparam int NVEC      = 8;
  localparam int SWEEP_CYC = 1 + NVEC * (SETTLE + 1);  // start edge -> done edge
  localparam int BUDGET    = 100;

  // Bench gate behaviours for the OR-golden checker.
  localparam int M_GOOD  = 0;
  localparam int M_STUCK = 1;
  localparam int M_FLIP5 = 2;

  typedef struct {
    int          err;
    logic [2:0]  ffv;
    logic        ffvalid;
    logic        pass;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  int   mode = M_GOOD;

  logic [2:0] dut_in_or, dut_in_and, ffv_or, ffv_and;
  logic       q_or, q_and;
  logic       busy_or, done_or, pass_or, ffvalid_or;
  logic       busy_and, done_and, pass_and, ffvalid_and;
  logic [3:0] err_or, err_and;

  exp_t       sb_q[$];
  logic [2:0] trace [0:SWEEP_CYC-1];
  int         n_checks = 0;
  int         n_pass = 0;

  always #5 clk = ~clk;

  function automatic logic gate_model(input int m, input logic [2:0] v);
    case (m)
      M_STUCK: return 1'b0;
      M_FLIP5: return (|v) ^ (v == 3'b101);
      default: return |v;
    endcase
  endfunction

  function automatic exp_t predict(input int m, input int func);
    exp_t       e;
    logic [2:0] vv;
    logic       g;
    e.err = 0; e.ffv = '0; e.ffvalid = 1'b0;
    for (int v = 0; v < NVEC; v++) begin
      vv = 3'(v);
      g  = (func == FUNC_AND) ? &vv : (func == FUNC_XOR) ? ^vv : |vv;
      if (gate_model(m, vv) !== g) begin
        e.err++;
        if (!e.ffvalid) begin
          e.ffv = vv;
          e.ffvalid = 1'b1;
        end
      end
    end
    e.pass = (e.err == 0);
    return e;
  endfunction

  always_comb q_or = gate_model(mode, dut_in_or);
  assign q_and = |dut_in_and;

  gate_response_checker #(.N_IN(N_IN), .SETTLE(SETTLE), .FUNC(FUNC_OR)) u_or (
    .clk(clk), .rst_n(rst_n), .start(start), .dut_in(dut_in_or), .dut_q(q_or),
    .busy(busy_or), .done(done_or), .pass(pass_or), .err_count(err_or),
    .first_fail_vec(ffv_or), .first_fail_valid(ffvalid_or)
  );

  gate_response_checker #(.N_IN(N_IN), .SETTLE(SETTLE), .FUNC(FUNC_AND)) u_and (
    .clk(clk), .rst_n(rst_n), .start(start), .dut_in(dut_in_and), .dut_q(q_and),
    .busy(busy_and), .done(done_and), .pass(pass_and), .err_count(err_and),
    .first_fail_vec(ffv_and), .first_fail_valid(ffvalid_and)
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a one-cycle start; returns 1 unit after the edge that sampled it.
  task automatic launch(input int m);
    mode = m;
    sb_q.push_back(predict(m, FUNC_OR));
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Count edges since the start edge until done, recording dut_in per cycle.
  task automatic wait_done(input int elapsed, output int cycles);
    cycles = elapsed;
    if (cycles < SWEEP_CYC) trace[cycles] = dut_in_or;
    while (!done_or && cycles < BUDGET) begin
      tick();
      cycles++;
      if (cycles < SWEEP_CYC) trace[cycles] = dut_in_or;
    end
  endtask

  // Wait for the sweep to end and score it against the oldest prediction.
  task automatic finish_sweep(input string name, input int elapsed);
    int   cyc;
    exp_t e;
    wait_done(elapsed, cyc);
    n_checks++;
    if (cyc != SWEEP_CYC) $display("FAIL %s latency: got %0d want %0d", name, cyc, SWEEP_CYC);
    else n_pass++;
    n_checks++;
    if (sb_q.size() == 0) begin
      $display("FAIL %s scoreboard: got empty queue want 1 entry", name);
      return;
    end else n_pass++;
    e = sb_q.pop_front();
    n_checks++;
    if (err_or !== 4'(e.err)) $display("FAIL %s err_count: got %0d want %0d", name, err_or, e.err);
    else n_pass++;
    n_checks++;
    if (ffvalid_or !== e.ffvalid) $display("FAIL %s first_fail_valid: got %b want %b", name, ffvalid_or, e.ffvalid);
    else n_pass++;
    if (e.ffvalid) begin
      n_checks++;
      if (ffv_or !== e.ffv) $display("FAIL %s first_fail_vec: got %b want %b", name, ffv_or, e.ffv);
      else n_pass++;
    end
    n_checks++;
    if ({pass_or, busy_or} !== {e.pass, 1'b0})
      $display("FAIL %s pass/busy: got %b/%b want %b/0", name, pass_or, busy_or, e.pass);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({dut_in_or, busy_or, done_or, pass_or, err_or, ffv_or, ffvalid_or} !== '0)
      $display("FAIL reset_outputs: got %b want all zero",
               {dut_in_or, busy_or, done_or, pass_or, err_or, ffv_or, ffvalid_or});
    else n_pass++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_good_or();
    launch(M_GOOD);
    n_checks++;
    if ({busy_or, dut_in_or} !== {1'b1, 3'b000})
      $display("FAIL good_busy_after_start: got %b/%b want 1/000", busy_or, dut_in_or);
    else n_pass++;
    finish_sweep("good_or", 0);
  endtask

  task automatic test_stuck_zero();
    int bad;
    logic [2:0] want;
    launch(M_STUCK);
    finish_sweep("stuck_zero", 0);
    bad = 0;
    for (int j = 0; j < SWEEP_CYC; j++) begin
      want = (j < NVEC * (SETTLE + 1)) ? 3'(j / (SETTLE + 1)) : 3'b111;
      if (trace[j] !== want) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL stuck_dut_in_order: got %0d bad cycles want 0", bad);
    else n_pass++;
  endtask

  task automatic test_single_flip();
    launch(M_FLIP5);
    finish_sweep("flip_101", 0);
  endtask

  task automatic test_and_golden();
    exp_t e;
    e = predict(M_GOOD, FUNC_AND);
    launch(M_GOOD);
    finish_sweep("and_run_or_side", 0);
    n_checks++;
    if ({done_and, pass_and, err_and, ffvalid_and, ffv_and} !== {1'b1, e.pass, 4'(e.err), e.ffvalid, e.ffv})
      $display("FAIL and_golden: got done=%b pass=%b err=%0d valid=%b vec=%b want 1 %b %0d %b %b",
               done_and, pass_and, err_and, ffvalid_and, ffv_and, e.pass, e.err, e.ffvalid, e.ffv);
    else n_pass++;
  endtask

  task automatic test_reset_mid_sweep();
    launch(M_STUCK);
    repeat (6) tick();
    rst_n = 1'b0;
    tick();
    n_checks++;
    if ({dut_in_or, busy_or, done_or, pass_or, err_or, ffv_or, ffvalid_or} !== '0)
      $display("FAIL midreset_outputs: got %b want all zero",
               {dut_in_or, busy_or, done_or, pass_or, err_or, ffv_or, ffvalid_or});
    else n_pass++;
    n_checks++;
    if (u_or.state !== ST_IDLE) $display("FAIL midreset_state: got %0d want %0d", u_or.state, ST_IDLE);
    else n_pass++;
    void'(sb_q.pop_back());
    rst_n = 1'b1;
    tick();
    launch(M_GOOD);
    finish_sweep("after_midreset", 0);
  endtask

  task automatic test_start_while_busy();
    launch(M_GOOD);
    repeat (4) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    finish_sweep("start_while_busy", 10);
  endtask

  task automatic test_restart_from_done();
    launch(M_STUCK);
    finish_sweep("fail_before_restart", 0);
    launch(M_GOOD);
    n_checks++;
    if ({done_or, busy_or, err_or, ffvalid_or} !== {1'b0, 1'b1, 4'd0, 1'b0})
      $display("FAIL restart_clear: got done=%b busy=%b err=%0d valid=%b want 0 1 0 0",
               done_or, busy_or, err_or, ffvalid_or);
    else n_pass++;
    finish_sweep("rerun_good", 0);
  endtask

  initial begin
    test_reset();
    test_good_or();
    test_stuck_zero();
    test_single_flip();
    test_and_golden();
    test_reset_mid_sweep();
    test_start_while_busy();
    test_restart_from_done();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want normal completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
